// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    PAR   = 2'b10
  } state_t;

  localparam logic S_IDLE = 1'b0;

  // Ceiling log2, never less than one bit so a 2-bit word still has a counter.
  function automatic int cnt_width(input int w);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word handshake and serial output bundle of the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             s_out;
  logic             s_valid;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, s_out, s_valid, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, s_out, s_valid, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// WIDTH-bit word to one-bit-per-clock serializer with gapless back-to-back words.
// Optional even-parity bit after each word when PISO_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic clr,
  piso_serializer_if.slave bus
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    cnt_reg;
  logic             s_out_reg;
  logic             s_valid_reg;
`ifdef PISO_PARITY_EN
  logic             parity_reg;
`endif

  logic             last_bit;
  logic             ready;
  logic             take;
  logic             load_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_next;

  // The first bit goes straight to s_out on load; the register keeps the rest.
  generate
    if (MSB_FIRST) begin : g_msb
      assign load_bit   = bus.din[WIDTH-1];
      assign load_rest  = {bus.din[WIDTH-2:0], 1'b0};
      assign next_bit   = shift_reg[WIDTH-1];
      assign shift_next = {shift_reg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign load_bit   = bus.din[0];
      assign load_rest  = {1'b0, bus.din[WIDTH-1:1]};
      assign next_bit   = shift_reg[0];
      assign shift_next = {1'b0, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (state_reg == SHIFT) && (cnt_reg == LAST);

`ifdef PISO_PARITY_EN
  assign ready = !clr && ((state_reg == IDLE) || (state_reg == PAR));
`else
  assign ready = !clr && ((state_reg == IDLE) || last_bit);
`endif

  assign take          = bus.din_valid && ready;
  assign bus.din_ready = ready;
  assign bus.s_out     = s_out_reg;
  assign bus.s_valid   = s_valid_reg;
  assign bus.busy      = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      s_out_reg   <= S_IDLE;
      s_valid_reg <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else if (take) begin
      // A transfer is only possible when the current word is finishing, so it always wins.
      state_reg   <= SHIFT;
      shift_reg   <= load_rest;
      cnt_reg     <= '0;
      s_out_reg   <= load_bit;
      s_valid_reg <= 1'b1;
`ifdef PISO_PARITY_EN
      parity_reg  <= ^bus.din;
`endif
    end else begin
      case (state_reg)
        SHIFT: begin
          if (cnt_reg != LAST) begin
            shift_reg <= shift_next;
            cnt_reg   <= cnt_reg + 1'b1;
            s_out_reg <= next_bit;
          end else begin
`ifdef PISO_PARITY_EN
            state_reg <= PAR;
            s_out_reg <= parity_reg;
`else
            state_reg   <= IDLE;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            s_out_reg   <= S_IDLE;
            s_valid_reg <= 1'b0;
`endif
          end
        end
        default: begin
          state_reg   <= IDLE;
          shift_reg   <= '0;
          cnt_reg     <= '0;
          s_out_reg   <= S_IDLE;
          s_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a queue-of-bits reference model.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bm ();
  piso_serializer_if #(.WIDTH(W)) bl ();

  assign bl.din       = bm.din;
  assign bl.din_valid = bm.din_valid;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .clr(clr), .bus(bm));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .clr(clr), .bus(bl));

  // Model: the bits still owed on the line, head = bit currently on s_out.
  bit qm[$];
  bit ql[$];
  int checks = 0;
  int errors = 0;
  bit last_take;

  function automatic void push_word(input logic [W-1:0] w);
    bit p;
    for (int i = 0; i < W; i++) begin
      qm.push_back(w[W-1-i]);
      ql.push_back(w[i]);
    end
    if (PAR_EN) begin
      p = ($countones(w) % 2) == 1;
      qm.push_back(p);
      ql.push_back(p);
    end
  endfunction

  always @(posedge clk) begin : model
    bit tk;
    if (clr) begin
      qm.delete();
      ql.delete();
    end else begin
      tk = bm.din_valid && (qm.size() <= 1);
      if (qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (tk) push_word(bm.din);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic c, input logic v, input logic [W-1:0] d);
    bit exp_ready;
    bit hm;
    bit hl;
    @(negedge clk);
    clr          = c;
    bm.din_valid = v;
    bm.din       = d;
    #1;
    exp_ready = !c && (qm.size() <= 1);
    hm = (qm.size() > 0) ? qm[0] : 1'b0;
    hl = (ql.size() > 0) ? ql[0] : 1'b0;
    check_eq("din_ready", 32'(bm.din_ready), 32'(exp_ready));
    check_eq("busy",      32'(bm.busy),      32'(qm.size() > 0));
    check_eq("s_valid_m", 32'(bm.s_valid),   32'(qm.size() > 0));
    check_eq("s_out_m",   32'(bm.s_out),     32'(hm));
    check_eq("s_valid_l", 32'(bl.s_valid),   32'(ql.size() > 0));
    check_eq("s_out_l",   32'(bl.s_out),     32'(hl));
    last_take = v && exp_ready;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    int n;
    n = 0;
    do begin
      drive(1'b0, 1'b1, w);
      n++;
    end while (!last_take && n < 40);
    check_eq("accept_in_time", 32'(last_take), 32'd1);
    $display("xfer word=%02h", w);
  endtask

  // Reassemble the next W bits as words: MSB instance shifts left, LSB instance shifts right.
  task automatic collect(output logic [W-1:0] m, output logic [W-1:0] l);
    m = '0;
    l = '0;
    for (int i = 0; i < W; i++) begin
      drive(1'b0, 1'b0, '0);
      m = {m[W-2:0], bm.s_out};
      l = {bl.s_out, l[W-1:1]};
    end
  endtask

  initial begin
    logic [W-1:0] m;
    logic [W-1:0] l;
    logic [W-1:0] rd;
    bm.din_valid = 1'b0;
    bm.din       = '0;

    drive(1'b1, 1'b1, 8'hFF);
    drive(1'b1, 1'b0, '0);
    check_eq("rst_s_out", 32'(bm.s_out), 32'd0);
    drive(1'b0, 1'b0, '0);

    send_word(8'hA5);
    collect(m, l);
    check_eq("a5_msb", 32'(m), 32'hA5);
    check_eq("a5_lsb", 32'(l), 32'hA5);
    drive(1'b0, 1'b0, '0);
    check_eq("after_a5_valid", 32'(bm.s_valid), 32'(PAR_EN));
    drive(1'b0, 1'b0, '0);

    send_word(8'h05);
    send_word(8'hA0);
    repeat (12) drive(1'b0, 1'b0, '0);

    send_word(8'h01);
    collect(m, l);
    check_eq("w01_msb", 32'(m), 32'h01);
    check_eq("w01_lsb", 32'(l), 32'h01);
    repeat (2) drive(1'b0, 1'b0, '0);

    send_word(8'hFF);
    repeat (3) drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 8'h00);
    drive(1'b0, 1'b0, '0);
    check_eq("midrst_busy", 32'(bm.busy), 32'd0);
    send_word(8'h80);
    collect(m, l);
    check_eq("w80_msb", 32'(m), 32'h80);
    check_eq("w80_lsb", 32'(l), 32'h80);

    send_word(8'h3C);
    collect(m, l);
    repeat (3) drive(1'b0, 1'b0, '0);
    send_word(8'hC3);
    collect(m, l);
    check_eq("stall_msb", 32'(m), 32'hC3);
    check_eq("stall_lsb", 32'(l), 32'hC3);
    repeat (2) drive(1'b0, 1'b0, '0);

    send_word(8'h07);
    collect(m, l);
    check_eq("w07_msb", 32'(m), 32'h07);
    drive(1'b0, 1'b0, '0);
    check_eq("w07_tail_valid", 32'(bm.s_valid), 32'(PAR_EN));
    check_eq("w07_tail_bit",   32'(bm.s_out),   32'(PAR_EN));
    repeat (2) drive(1'b0, 1'b0, '0);

    for (int i = 0; i < 500; i++) begin
      rd = W'($urandom);
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6), rd);
      if (last_take) $display("xfer word=%02h", rd);
    end
    repeat (12) drive(1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that converts WIDTH-bit words into a one-bit-per-clock stream.
- Sits directly upstream of the serial sequence detector and drives its serial input.
- Accepts words through a valid/ready handshake; emits bits with a qualifying strobe.
- Supports gapless back-to-back words so the downstream detector sees a continuous bit stream.

Parameters:
- WIDTH, 8, data word width in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous active-high reset, sampled on rising clk.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block can accept din this cycle (combinational from state).
- s_out  output  1  serial data bit, driven directly from a register.
- s_valid  output  1  s_out carries a real data or parity bit this cycle.
- busy  output  1  high while a word or parity bit is in flight (state != IDLE).

Behaviour:
- Reset: on a clk edge with clr=1, outputs become state=IDLE, s_out=0, s_valid=0, busy=0, shift register=0, bit counter=0. While clr=1, din_ready=0.
- Handshake: a word transfers on a clk edge where din_valid & din_ready. din is ignored at all other times. din_valid may drop without a transfer.
- din_ready=1 under any of these conditions:
  - state=IDLE;
  - state=SHIFT with the last data bit on s_out and parity disabled;
  - state=PAR.
- FSM states: IDLE, SHIFT, PAR (PAR exists only with PARITY_EN).
  - IDLE -> SHIFT on transfer.
  - SHIFT -> SHIFT while bit counter < WIDTH-1.
  - On the last bit, SHIFT goes to PAR when parity is enabled.
  - Otherwise, on the last bit: SHIFT -> SHIFT on a new transfer, else IDLE.
  - PAR -> SHIFT on transfer, else IDLE.
- Latency:
  - A word transferred at edge N drives its first bit at cycle N+1 and its last bit at cycle N+WIDTH.
  - In SHIFT and PAR, s_valid=1 every cycle. No bubbles within a word.
- Back-to-back: a transfer on the final-bit cycle puts the next word's first bit at N+WIDTH+1, giving zero idle cycles between words.
- Idle line: in IDLE, s_out=0 and s_valid=0, so the downstream detector sees 0s when no data is sent.
- Bit order: MSB_FIRST selects shift direction. The remaining bits are held in the shift register and the bit counter counts 0..WIDTH-1, with no wrap beyond WIDTH-1.
- Reset mid-word: the partially sent word is discarded with no resumption. The next transfer is possible one cycle after clr deasserts.
- Simultaneous clr and din_valid: clr wins and no transfer occurs.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit, one extra cycle in state PAR drives s_out = even parity (XOR of all WIDTH bits of the word) with s_valid=1.
  - Words occupy WIDTH+1 cycles.
  - din_ready during the last data bit is 0; it is 1 in PAR.
- Undefined: no PAR state, no parity logic, words occupy WIDTH cycles.

Decomposition:
- Shared package piso_pkg holds:
  - state encodings: IDLE=2'b00, SHIFT=2'b01, PAR=2'b10;
  - the counter-width function (ceiling log2 of WIDTH);
  - idle-line constant S_IDLE=1'b0.
- No sub-module is natural. The FSM, shift register and counter stay in one module.

Test Plan:
- Reset then single word: WIDTH=8, MSB_FIRST=1, din=8'hA5 accepted at edge 0.
  - Required: s_out = 1,0,1,0,0,1,0,1 on cycles 1..8, s_valid=1 on cycles 1..8.
  - Required: cycle 9 has s_valid=0, s_out=0, din_ready=1.
- Back-to-back words: 8'h05 then 8'hA0 with din_valid held.
  - Required: 16 consecutive s_valid cycles, stream 00000101_10100000.
  - Required: din_ready=1 on cycles 0, 8 and 16 only.
- LSB-first: MSB_FIRST=0, din=8'h01.
  - Required: s_out=1 on cycle 1, then 0 on cycles 2..8.
- Reset mid-word: clr=1 at cycle 4 of 8'hFF.
  - Required: cycle 5 has s_out=0, s_valid=0, busy=0.
  - Required: a new word 8'h80 accepted after clr drops emits 1 then seven 0s.
- Stall: din_valid=0 for 3 cycles between two words.
  - Required: 3 idle cycles with s_valid=0 and s_out=0.
  - Required: no duplicated or dropped bits.
- PISO_PARITY_EN defined: din=8'h07.
  - Required: 8 data bits, then cycle 9 s_out=1 with s_valid=1.
  - Required: din_ready=0 on cycle 8 and 1 on cycle 9.
